// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with start/busy/done handshake.
// Optional macro LEADING_ZERO_BLANK_EN adds a registered per-digit leading-zero blank output.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    // Scratch carries one extra digit so an out-of-range value never corrupts a kept digit.
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = 64'(10) ** DIGITS - 64'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [BIN_W-1:0]     shift_reg;
    logic [SCR_W-1:0]     scratch_reg;
    logic [SCR_W-1:0]     corrected;
    logic [SCR_W-1:0]     scratch_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 ovf_pend_reg;
    logic [4*DIGITS-1:0]  bcd_reg;
    logic                 ovf_reg;
    logic                 accept;
    logic                 last_shift;

    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_shift = (state_reg == SHIFT) && (cnt_reg == CNT_W'(1));

    // Add-3 correction on every scratch digit, then shift in the next binary bit.
    generate
        for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_corr
            logic [3:0] dig;
            assign dig = scratch_reg[4*gi +: 4];
            assign corrected[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
    endgenerate

    assign scratch_next = SCR_W'({corrected, shift_reg[BIN_W-1]});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = (cnt_reg == CNT_W'(1)) ? DONE : SHIFT;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            bcd_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else if (accept) begin
            shift_reg    <= bin_in;
            scratch_reg  <= '0;
            cnt_reg      <= CNT_W'(BIN_W);
            ovf_pend_reg <= (64'(bin_in) > MAX_VAL);
        end else if (state_reg == SHIFT) begin
            shift_reg   <= {shift_reg[BIN_W-2:0], 1'b0};
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_reg - CNT_W'(1);
            if (last_shift) begin
                bcd_reg <= ovf_pend_reg ? {DIGITS{4'h9}} : scratch_next[4*DIGITS-1:0];
                ovf_reg <= ovf_pend_reg;
            end
        end
    end

    assign bcd_out  = bcd_reg;
    assign overflow = ovf_reg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS:0]   zero_from;
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_reg;

    // zero_from[i] is set when digit i and every higher kept digit are zero.
    assign zero_from[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign zero_from[gi] = (scratch_next[4*gi +: 4] == 4'd0) && zero_from[gi+1];
            if (gi == 0) begin : g_units
                assign blank_next[gi] = 1'b0;
            end else begin : g_upper
                assign blank_next[gi] = zero_from[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_reg <= '0;
        end else if (last_shift) begin
            blank_reg <= ovf_pend_reg ? '0 : blank_next;
        end
    end

    assign blank = blank_reg;
`endif

endmodule
